// File: rtl/pico_io_pkg.sv
// rtl/pico_io_pkg.sv - port map and register bit indices for the pico I/O bridge
package pico_io_pkg;

    localparam logic [7:0] PORT_TX       = 8'h00;
    localparam logic [7:0] PORT_CTRL     = 8'h01;
    localparam logic [7:0] PORT_RX       = 8'h02;
    localparam logic [7:0] PORT_STAT     = 8'h03;
    localparam logic [7:0] PORT_GPO_BASE = 8'h04;

    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_TX_FLUSH = 1;

    localparam int STAT_IRQ      = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_TX_FULL  = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_RX_OVF   = 5;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-buffer FIFO with push/pop/flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A pop on an empty FIFO is ignored; a pop on a full FIFO frees room for a same-cycle push.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;

    // Pointer, count and storage update; flush overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/pico_port_bridge.sv
// rtl/pico_port_bridge.sv - port-mapped TX FIFO, RX holding register, GPO and interrupt for pico_top
module pico_port_bridge
    import pico_io_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic       clk,
    input  logic       cpu_reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       k_write_strobe,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic [7:0] in_port,
    output logic       interrupt,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] gpo0,
    output logic [7:0] gpo1,
    output logic [7:0] gpo2,
    output logic [7:0] gpo3
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_addr;
    logic          tx_push;
    logic          ctrl_wr;
    logic          tx_flush;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_drop;
    logic [CW-1:0] tx_count;
    logic [7:0]    ctrl;
    logic [7:0]    rx_hold;
    logic          rx_full;
    logic          rx_ovf;
    logic          tx_ovf;
    logic          rd_rx;
    logic          rd_stat;
    logic          rx_load;
    logic [7:0]    status;

    // OUTPUTK only carries a 4-bit port; the full-address OUTPUT decode wins if both fire.
    assign wr_en    = write_strobe | k_write_strobe;
    assign wr_addr  = write_strobe ? port_id : {4'h0, port_id[3:0]};
    assign tx_push  = wr_en && (wr_addr == PORT_TX);
    assign ctrl_wr  = wr_en && (wr_addr == PORT_CTRL);
    assign tx_flush = ctrl_wr & out_port[CTRL_TX_FLUSH];

    assign rd_rx    = read_strobe && (port_id == PORT_RX);
    assign rd_stat  = read_strobe && (port_id == PORT_STAT);
    // A pop in the same cycle as a new byte makes room, so the byte is taken without overflow.
    assign rx_load  = rx_strobe & (~rx_full | rd_rx);
    assign tx_valid = ~tx_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (cpu_reset),
        .push      (tx_push),
        .push_data (out_port),
        .pop       (tx_ready),
        .flush     (tx_flush),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .drop      (tx_drop),
        .count     (tx_count)
    );

    // Status word assembled from live flags.
    always_comb begin
        status                = '0;
        status[STAT_IRQ]      = interrupt;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_TX_OVF]   = tx_ovf;
        status[STAT_RX_OVF]   = rx_ovf;
    end

    // Control and GPO registers; the flush bit is a pulse and is never stored.
    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            ctrl <= '0;
            gpo0 <= '0;
            gpo1 <= '0;
            gpo2 <= '0;
            gpo3 <= '0;
        end else if (wr_en) begin
            if (ctrl_wr) begin
                ctrl <= out_port & ~(8'h01 << CTRL_TX_FLUSH);
            end
            if (wr_addr[7:2] == PORT_GPO_BASE[7:2]) begin
                case (wr_addr[1:0])
                    2'd0:    gpo0 <= out_port;
                    2'd1:    gpo1 <= out_port;
                    2'd2:    gpo2 <= out_port;
                    default: gpo3 <= out_port;
                endcase
            end
        end
    end

    // RX holding register and sticky overflow flags; a new event beats a same-cycle status clear.
    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            rx_hold <= '0;
            rx_full <= 1'b0;
            rx_ovf  <= 1'b0;
            tx_ovf  <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_hold <= rx_data;
                rx_full <= 1'b1;
            end else if (rd_rx) begin
                rx_full <= 1'b0;
            end
            if (rx_strobe && !rx_load) begin
                rx_ovf <= 1'b1;
            end else if (rd_stat) begin
                rx_ovf <= 1'b0;
            end
            if (tx_drop) begin
                tx_ovf <= 1'b1;
            end else if (rd_stat) begin
                tx_ovf <= 1'b0;
            end
        end
    end

    // Interrupt latches on a receive load while enabled; set beats a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            interrupt <= 1'b0;
        end else if (rx_load && ctrl[CTRL_IRQ_EN]) begin
            interrupt <= 1'b1;
        end else if (interrupt_ack) begin
            interrupt <= 1'b0;
        end
    end

    // Read data is registered from port_id every cycle so it is stable during read_strobe.
    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            in_port <= '0;
        end else begin
            case (port_id)
                PORT_TX:   in_port <= 8'(tx_count);
                PORT_CTRL: in_port <= ctrl;
                PORT_RX:   in_port <= rx_hold;
                PORT_STAT: in_port <= status;
                default:   in_port <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_port_bridge.sv
// tb/tb_pico_port_bridge.sv - scoreboard bench for pico_port_bridge
module tb_pico_port_bridge;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       cpu_reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] in_port;
    logic       interrupt;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] gpo0, gpo1, gpo2, gpo3;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb [$];
    int         model_level = 0;
    logic [7:0] rd;

    always #5 clk = ~clk;

    pico_port_bridge #(.TX_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .cpu_reset      (cpu_reset),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .interrupt_ack  (interrupt_ack),
        .in_port        (in_port),
        .interrupt      (interrupt),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_strobe      (rx_strobe),
        .gpo0           (gpo0),
        .gpo1           (gpo1),
        .gpo2           (gpo2),
        .gpo3           (gpo3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // TX consumer side: every accepted byte must match the scoreboard head.
    always @(negedge clk) begin
        if (!cpu_reset && tx_valid && tx_ready) begin
            check("tx_sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                check("tx_byte", tx_data, sb.pop_front());
                model_level--;
            end
        end
    end

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                            input logic ws, input logic ks);
        logic [7:0] ea;
        ea = ws ? addr : {4'h0, addr[3:0]};
        port_id = addr;
        out_port = data;
        write_strobe = ws;
        k_write_strobe = ks;
        if ((ws || ks) && ea == 8'h00 && model_level < DEPTH) begin
            sb.push_back(data);
            model_level++;
        end
        if ((ws || ks) && ea == 8'h01 && data[1]) begin
            sb.delete();
            model_level = 0;
        end
        @(posedge clk); #1;
        write_strobe = 1'b0;
        k_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
        port_id = addr;
        @(posedge clk); #1;
        read_strobe = 1'b1;
        data = in_port;
        @(posedge clk); #1;
        read_strobe = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b;
        rx_strobe = 1'b1;
        @(posedge clk); #1;
        rx_strobe = 1'b0;
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        @(posedge clk); #1;
        interrupt_ack = 1'b0;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("drain_done", sb.size(), 0);
    endtask

    initial begin
        cpu_reset = 1'b1;
        port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
        interrupt_ack = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cpu_reset = 1'b0;

        // Reset state
        check("rst_in_port", in_port, 8'h00);
        check("rst_interrupt", interrupt, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_gpo", {gpo3, gpo2, gpo1, gpo0}, 32'h0);
        io_read(8'h03, rd); check("rst_status", rd, 8'h02);
        io_read(8'h01, rd); check("rst_ctrl", rd, 8'h00);

        // TX path
        io_write(8'h00, 8'hA5, 1'b1, 1'b0);
        io_write(8'h00, 8'h3C, 1'b1, 1'b0);
        io_read(8'h00, rd); check("tx_level2", rd, 8'd2);
        check("tx_head", tx_data, 8'hA5);
        drain();
        check("tx_valid_after_drain", tx_valid, 1'b0);

        // TX overflow
        for (int i = 1; i <= 9; i++) io_write(8'h00, 8'(i), 1'b1, 1'b0);
        io_read(8'h03, rd); check("tx_ovf_status", rd, 8'h14);
        io_read(8'h03, rd); check("tx_ovf_cleared", rd, 8'h04);
        io_read(8'h00, rd); check("tx_level_full", rd, 8'd8);
        drain();
        io_write(8'h00, 8'h0A, 1'b1, 1'b0);
        io_write(8'h00, 8'h0B, 1'b1, 1'b0);
        check("tx_valid_before_flush", tx_valid, 1'b1);
        io_write(8'h01, 8'h02, 1'b1, 1'b0);
        check("tx_flush", tx_valid, 1'b0);
        io_read(8'h01, rd); check("ctrl_flush_reads0", rd, 8'h00);

        // RX and interrupt
        io_write(8'h01, 8'h01, 1'b1, 1'b0);
        rx_pulse(8'h5A);
        check("irq_set", interrupt, 1'b1);
        ack_pulse();
        check("irq_ack", interrupt, 1'b0);
        io_read(8'h02, rd); check("rx_byte", rd, 8'h5A);
        io_read(8'h03, rd); check("rx_popped_status", rd, 8'h02);

        // RX overflow and simultaneous events
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        io_read(8'h03, rd); check("rx_ovf_status", rd, 8'h2B);
        port_id = 8'h02;
        @(posedge clk); #1;
        read_strobe = 1'b1; rx_data = 8'h33; rx_strobe = 1'b1; interrupt_ack = 1'b1;
        rd = in_port;
        @(posedge clk); #1;
        read_strobe = 1'b0; rx_strobe = 1'b0; interrupt_ack = 1'b0;
        check("rx_kept_first", rd, 8'h11);
        check("irq_set_beats_ack", interrupt, 1'b1);
        io_read(8'h03, rd); check("rx_pop_load_status", rd, 8'h0B);
        io_write(8'h01, 8'h00, 1'b1, 1'b0);
        check("irq_kept_on_disable", interrupt, 1'b1);
        ack_pulse();
        check("irq_ack2", interrupt, 1'b0);
        io_read(8'h02, rd); check("rx_byte_33", rd, 8'h33);
        rx_pulse(8'h44);
        check("irq_disabled", interrupt, 1'b0);
        io_read(8'h02, rd); check("rx_byte_44", rd, 8'h44);
        io_read(8'h03, rd); check("rx_final_status", rd, 8'h02);

        // OUTPUTK and GPO
        io_write(8'hF6, 8'h7E, 1'b0, 1'b1);
        check("k_gpo2", gpo2, 8'h7E);
        io_write(8'hF6, 8'h99, 1'b1, 1'b0);
        check("full_addr_ignored", gpo2, 8'h7E);
        io_write(8'h04, 8'h12, 1'b1, 1'b0);
        check("gpo0", gpo0, 8'h12);
        io_write(8'h07, 8'hC3, 1'b1, 1'b0);
        check("gpo3", gpo3, 8'hC3);
        io_write(8'h15, 8'h5C, 1'b1, 1'b1);
        check("both_strobes_ws_wins", gpo1, 8'h00);
        io_write(8'h01, 8'hF3, 1'b1, 1'b0);
        io_read(8'h01, rd); check("ctrl_readback", rd, 8'hF1);
        io_read(8'h09, rd); check("unmapped_read", rd, 8'h00);

        // Reset mid-operation discards FIFO contents
        io_write(8'h00, 8'h55, 1'b0, 1'b1);
        check("tx_valid_k_push", tx_valid, 1'b1);
        cpu_reset = 1'b1;
        @(posedge clk); #1;
        cpu_reset = 1'b0;
        sb.delete();
        model_level = 0;
        check("rst_mid_tx_valid", tx_valid, 1'b0);
        check("rst_mid_gpo", {gpo3, gpo2, gpo1, gpo0}, 32'h0);
        io_read(8'h00, rd); check("rst_mid_level", rd, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
